cbc_chain_ctrl: RTL and testbench

CBC_CHAIN_CTRL -- requirements
Module: cbc_chain_ctrl

---
 rtl/cbc_chain_ctrl_pkg.sv | 21 ++
 rtl/cbc_e.sv | 102 ++++++++++
 rtl/cbc_e_top.sv | 59 +++++
 rtl/cbc_chain_ctrl.sv | 114 +++++++++++
 tb/tb_cbc_chain_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbc_chain_ctrl_pkg.sv
// Shared types and constants for the CBC chaining controller.
// Holds the FSM encoding, widths, core latency default and GF helpers.
package cbc_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int BLK_W        = 128;
  localparam int CORE_LAT_DEF = 2;
  localparam int CNT_W        = 16;
  localparam int SETTLE_W     = 4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/cbc_e.sv
// Combinational AES-128 encrypt core for CBC: ct = E(key, image ^ iv).
// Fully unrolled; the controller gives it CORE_LAT cycles to settle.
module cbc_e
  import cbc_chain_ctrl_pkg::*;
(
  input  logic [BLK_W-1:0] i_image,
  input  logic [BLK_W-1:0] i_iv,
  input  logic [BLK_W-1:0] i_key,
  output logic [BLK_W-1:0] o_ct
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  // Byte 0 is the MSB; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] next_key(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
    t  = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] w_s;
  logic [127:0] w_k;
  logic [7:0]   w_rc;

  always_comb begin
    w_k  = i_key;
    w_s  = i_image ^ i_iv ^ i_key;
    w_rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w_s = sub_shift(w_s);
      if (r < 10) w_s = mix(w_s);
      w_k  = next_key(w_k, w_rc);
      w_rc = xtime(w_rc);
      w_s  = w_s ^ w_k;
    end
  end

  assign o_ct = w_s;

endmodule

// File: rtl/cbc_e_top.sv
// CBC encrypt wrapper: chaining controller plus the combinational core.
// The controller carries no AES logic of its own.
module cbc_e_top
  import cbc_chain_ctrl_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BLK_W-1:0] key_in,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic             ct_valid,
  output logic [BLK_W-1:0] ct_data,
  output logic             ct_last,
  input  logic             ct_ready,
  output logic [CNT_W-1:0] blk_count
);

  logic [BLK_W-1:0] w_image;
  logic [BLK_W-1:0] w_iv;
  logic [BLK_W-1:0] w_key;
  logic [BLK_W-1:0] w_ct;

  cbc_chain_ctrl #(
    .CORE_LAT (CORE_LAT)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .iv_in      (iv_in),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .blk_ready  (blk_ready),
    .core_image (w_image),
    .core_iv    (w_iv),
    .core_key   (w_key),
    .core_ct    (w_ct),
    .ct_valid   (ct_valid),
    .ct_data    (ct_data),
    .ct_last    (ct_last),
    .ct_ready   (ct_ready),
    .blk_count  (blk_count)
  );

  cbc_e u_core (
    .i_image (w_image),
    .i_iv    (w_iv),
    .i_key   (w_key),
    .o_ct    (w_ct)
  );

endmodule

// File: rtl/cbc_chain_ctrl.sv
// CBC chaining controller: feeds one block at a time to an external
// combinational encrypt core and chains each ciphertext into the next IV.
module cbc_chain_ctrl
  import cbc_chain_ctrl_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BLK_W-1:0] key_in,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic [BLK_W-1:0] core_image,
  output logic [BLK_W-1:0] core_iv,
  output logic [BLK_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_ct,
  output logic             ct_valid,
  output logic [BLK_W-1:0] ct_data,
  output logic             ct_last,
  input  logic             ct_ready,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [SETTLE_W-1:0] LAT_M1 = SETTLE_W'(CORE_LAT - 1);

  state_e              r_state;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_last;
  logic                r_blk_ready;
  logic [BLK_W-1:0]    r_core_image;
  logic [BLK_W-1:0]    r_core_iv;
  logic [BLK_W-1:0]    r_core_key;
  logic                r_ct_valid;
  logic [BLK_W-1:0]    r_ct_data;
  logic                r_ct_last;
  logic [CNT_W-1:0]    r_blk_count;

  logic w_blk_hs;
  logic w_ct_hs;

  assign w_blk_hs = blk_valid & r_blk_ready;
  assign w_ct_hs  = r_ct_valid & ct_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle     <= '0;
      r_last       <= 1'b0;
      r_blk_ready  <= 1'b0;
      r_core_image <= '0;
      r_core_iv    <= '0;
      r_core_key   <= '0;
      r_ct_valid   <= 1'b0;
      r_ct_data    <= '0;
      r_ct_last    <= 1'b0;
      r_blk_count  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_core_key  <= key_in;
            r_core_iv   <= iv_in;
            r_blk_count <= '0;
            r_blk_ready <= 1'b1;
            r_state     <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (w_blk_hs) begin
            r_core_image <= blk_data;
            r_last       <= blk_last;
            r_settle     <= LAT_M1;
            r_blk_ready  <= 1'b0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == '0) begin
            r_ct_data  <= core_ct;
            r_ct_valid <= 1'b1;
            r_ct_last  <= r_last;
            r_state    <= ST_HOLD;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_ct_hs) begin
            r_core_iv   <= r_ct_data;
            r_blk_count <= r_blk_count + 1'b1;
            r_ct_valid  <= 1'b0;
            r_blk_ready <= ~r_ct_last;
            r_state     <= r_ct_last ? ST_IDLE : ST_ACCEPT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign blk_ready  = r_blk_ready;
  assign core_image = r_core_image;
  assign core_iv    = r_core_iv;
  assign core_key   = r_core_key;
  assign ct_valid   = r_ct_valid;
  assign ct_data    = r_ct_data;
  assign ct_last    = r_ct_last;
  assign blk_count  = r_blk_count;

endmodule

// File: tb/tb_cbc_chain_ctrl.sv
// Scoreboard bench for cbc_chain_ctrl driven by the cbc_e core.
// Expected ciphertexts are SP800-38A CBC-AES128 reference values.
module tb_cbc_chain_ctrl;
  import cbc_chain_ctrl_pkg::*;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

  typedef struct {
    logic [127:0] ct;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] iv_in = '0;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         blk_ready;
  logic [127:0] core_image;
  logic [127:0] core_iv;
  logic [127:0] core_key;
  logic [127:0] core_ct;
  logic         ct_valid;
  logic [127:0] ct_data;
  logic         ct_last;
  logic         ct_ready = 1'b1;
  logic [15:0]  blk_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  int   cyc     = 0;
  int   cv_cyc  = 0;
  int   hs_cyc  = 0;
  logic prev_cv = 1'b0;
  exp_t sb_q[$];

  cbc_chain_ctrl #(.CORE_LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .iv_in      (iv_in),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .blk_ready  (blk_ready),
    .core_image (core_image),
    .core_iv    (core_iv),
    .core_key   (core_key),
    .core_ct    (core_ct),
    .ct_valid   (ct_valid),
    .ct_data    (ct_data),
    .ct_last    (ct_last),
    .ct_ready   (ct_ready),
    .blk_count  (blk_count)
  );

  cbc_e u_core (
    .i_image (core_image),
    .i_iv    (core_iv),
    .i_key   (core_key),
    .o_ct    (core_ct)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ct_valid && !prev_cv) cv_cyc <= cyc;
    prev_cv <= ct_valid;
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pops one expectation per ciphertext handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ct_valid && ct_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_ct", 128'(ct_data), 128'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ct_data", ct_data, e.ct);
          chk("ct_last", 128'(ct_last), 128'(e.last));
        end
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] iv);
    start  = 1'b1;
    key_in = k;
    iv_in  = iv;
    tick();
    start  = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] d, input logic lst,
                          input logic [127:0] exp, input logic push);
    logic hs;
    exp_t e;
    if (push) begin
      e.ct   = exp;
      e.last = lst;
      sb_q.push_back(e);
    end
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = lst;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = blk_ready;
      hs_cyc = cyc;
      tick();
    end
    if (!hs) chk("blk_hs_timeout", 128'(0), 128'(1));
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic wait_pop(input int target);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_pop >= target) return;
    end
    chk("ct_timeout", 128'(n_pop), 128'(target));
  endtask

  initial begin
    int base;
    logic ok;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_blk_ready", 128'(blk_ready), 128'(0));
    chk("rst_ct_valid", 128'(ct_valid), 128'(0));
    chk("rst_ct_last", 128'(ct_last), 128'(0));
    chk("rst_ct_data", ct_data, 128'(0));
    chk("rst_core_key", core_key, 128'(0));
    chk("rst_core_iv", core_iv, 128'(0));
    chk("rst_core_image", core_image, 128'(0));
    chk("rst_blk_count", 128'(blk_count), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // SP800-38A two-block message, with latency measurement
    do_start(K, IV);
    chk("start_key", core_key, K);
    chk("start_iv", core_iv, IV);
    send_blk(P1, 1'b0, C1, 1'b1);
    wait_pop(1);
    chk("latency", 128'(cv_cyc - hs_cyc), 128'(3));
    chk("cnt_after_p1", 128'(blk_count), 128'(1));
    chk("chain_iv", core_iv, C1);
    send_blk(P2, 1'b1, C2, 1'b1);
    wait_pop(2);
    chk("cnt_after_p2", 128'(blk_count), 128'(2));
    tick();
    chk("idle_state", 128'(dut.r_state), 128'(ST_IDLE));
    chk("idle_blk_ready", 128'(blk_ready), 128'(0));

    // Backpressure: ct_ready low for 10 cycles
    do_start(K, IV);
    ct_ready = 1'b0;
    send_blk(P1, 1'b0, C1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = ct_valid;
    end
    chk("bp_ct_valid_seen", 128'(ok), 128'(1));
    base = n_pop;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ct_data", ct_data, C1);
      chk("bp_blk_ready", 128'(blk_ready), 128'(0));
      chk("bp_ct_valid", 128'(ct_valid), 128'(1));
    end
    chk("bp_cnt_hold", 128'(blk_count), 128'(0));
    tick();
    ct_ready = 1'b1;
    wait_pop(base + 1);
    chk("bp_cnt", 128'(blk_count), 128'(1));
    repeat (5) tick();
    chk("bp_single_hs", 128'(n_pop - base), 128'(1));
    send_blk(P2, 1'b1, C2, 1'b1);
    wait_pop(base + 2);
    chk("bp_cnt2", 128'(blk_count), 128'(2));
    tick();

    // start while in ACCEPT is ignored
    do_start(K, IV);
    tick();
    do_start(128'h0, IV2);
    chk("ign_iv", core_iv, IV);
    chk("ign_key", core_key, K);
    base = n_pop;
    send_blk(P1, 1'b0, C1, 1'b1);
    wait_pop(base + 1);
    send_blk(P2, 1'b1, C2, 1'b1);
    wait_pop(base + 2);
    tick();

    // Reset in the middle of SETTLE
    do_start(K, IV2);
    base = n_pop;
    send_blk(P2, 1'b0, 128'h0, 1'b0);
    chk("mid_state", 128'(dut.r_state), 128'(ST_SETTLE));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_ct_valid", 128'(ct_valid), 128'(0));
    chk("mr_ct_data", ct_data, 128'(0));
    chk("mr_core_image", core_image, 128'(0));
    chk("mr_core_iv", core_iv, 128'(0));
    chk("mr_core_key", core_key, 128'(0));
    chk("mr_blk_ready", 128'(blk_ready), 128'(0));
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("mr_no_ct", 128'(n_pop - base), 128'(0));
    chk("mr_need_start", 128'(blk_ready), 128'(0));
    do_start(K, IV);
    send_blk(P1, 1'b0, C1, 1'b1);
    wait_pop(base + 1);
    send_blk(P2, 1'b1, C2, 1'b1);
    wait_pop(base + 2);
    tick();

    // blk_count wrap
    do_start(K, IV);
    force dut.r_blk_count = 16'hFFFF;
    tick();
    release dut.r_blk_count;
    tick();
    chk("wrap_pre", 128'(blk_count), 128'(16'hFFFF));
    base = n_pop;
    send_blk(P1, 1'b0, C1, 1'b1);
    wait_pop(base + 1);
    chk("wrap_cnt", 128'(blk_count), 128'(0));

    repeat (3) tick();
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
